// File: rtl/cpu_pkg.sv
// Shared CPU constants, fetch FSM encoding and opcodes.
// Imported by the fetch stage and its helpers.
package cpu_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int RESET_PC = 0;
  localparam logic [31:0] HLT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/instr_fetch_unit_pc_next_mux.sv
// Next-PC selector: redirect > stall > increment (wraps).
// Ports: pc, target, redirect, stall in; pc_next out.
module pc_next_mux #(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  input  logic              redirect,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc_next
);

  // Redirect and stall may both be high; the
  // older control transfer must win.
  always_comb begin
    pc_next = pc + ADDR_W'(1);
    priority case (1'b1)
      redirect: pc_next = target;
      stall:    pc_next = pc;
      default:  pc_next = pc + ADDR_W'(1);
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, drives the 1-cycle ROM, parks on HLT.
// Ports: stall/redirect in, imem addr/data, IF/ID bundle, halted, fetch_count.
module instr_fetch_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0] HLT_WORD = DATA_W'(cpu_pkg::HLT_WORD),
  parameter int RESET_PC = cpu_pkg::RESET_PC,
  parameter int CNT_W = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic [DATA_W-1:0] imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus1,
  output logic              if_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);
  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_next;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;

  pc_next_mux #(.ADDR_W(ADDR_W)) u_mux (
    .pc       (pc_q),
    .target   (redirect_target),
    .redirect (redirect),
    .stall    (stall),
    .pc_next  (pc_next)
  );

  // In RUN the ROM is addressed with pc_next so
  // imem_data lines up with pc_q after the edge.
  always_comb begin
    state_d   = state_q;
    imem_addr = pc_q;
    if_valid  = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        imem_addr = pc_next;
        if_valid  = valid_q & ~redirect;
        if (if_valid && !stall &&
            imem_data == HLT_WORD)
          state_d = HALT;
      end
      HALT: halted = 1'b1;
      default: state_d = BOOT;
    endcase
  end

  assign accept = if_valid & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= ADDR_W'(RESET_PC);
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == RUN);
      // Entering HALT keeps the HLT address.
      if (state_q == RUN && state_d == RUN)
        pc_q <= pc_next;
      if (accept && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign if_instr    = imem_data;
  assign if_pc       = pc_q;
  assign if_pc_plus1 = pc_q + ADDR_W'(1);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed plan plus random
// stimulus against a behavioural fetch model.
module tb_instr_fetch_unit;

  localparam logic [31:0] ADD = 32'h0021_0820;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [9:0]  redirect_target = '0;
  logic [31:0] imem_data = 32'h1;
  logic [9:0]  imem_addr;
  logic [31:0] if_instr;
  logic [9:0]  if_pc;
  logic [9:0]  if_pc_plus1;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] rom [1024];

  int checks = 0;
  int failures = 0;

  // Model: phase 0=waiting first edge, 1=fetching, 2=parked.
  int m_phase = 0;
  int m_pc = 0;
  int m_cnt = 0;
  bit c_s, c_r;
  int c_t;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_data       (imem_data),
    .imem_addr       (imem_addr),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus1     (if_pc_plus1),
    .if_valid        (if_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic int nxt();
    if (c_r) return c_t;
    if (c_s) return m_pc;
    return (m_pc + 1) % 1024;
  endfunction

  task automatic model_check();
    bit ev;
    int ea;
    ev = (m_phase == 1) && !c_r;
    ea = (m_phase == 1) ? nxt() : m_pc;
    chk("m_valid", {31'b0, if_valid}, {31'b0, ev});
    chk("m_halted", {31'b0, halted},
        {31'b0, m_phase == 2});
    chk("m_addr", imem_addr, ea);
    chk("m_pc", if_pc, m_pc);
    chk("m_pc1", if_pc_plus1, (m_pc + 1) % 1024);
    chk("m_cnt", fetch_count, m_cnt);
    if (ev) chk("m_instr", if_instr, rom[m_pc]);
  endtask

  task automatic set_in(input bit s, input bit r,
                        input int t);
    @(negedge clk);
    stall = s;
    redirect = r;
    redirect_target = 10'(t);
    c_s = s;
    c_r = r;
    c_t = t;
    #1;
    model_check();
  endtask

  task automatic tick();
    bit v;
    @(posedge clk);
    if (rst_n) begin
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        v = !c_r && !c_s;
        if (v && m_cnt < 65535) m_cnt++;
        if (v && rom[m_pc] == 32'h0) m_phase = 2;
        else m_pc = nxt();
      end
    end
  endtask

  task automatic go(input bit s, input bit r,
                    input int t);
    set_in(s, r, t);
    tick();
  endtask

  // Called right after set_in, before the next edge.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, if_valid}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_cnt", fetch_count, 0);
    m_phase = 0;
    m_pc = 0;
    m_cnt = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      rom[i] = 32'h1000_0000 | i;
    for (int i = 0; i < 4; i++) rom[i] = ADD;
    rom[6] = 32'h0;
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    set_in(0, 0, 0);
    do_reset();

    // 1: straight-line fetch from reset
    set_in(0, 0, 0);
    chk("t1_boot_valid", {31'b0, if_valid}, 0);
    chk("t1_boot_addr", imem_addr, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0);
      chk("t1_pc", if_pc, i);
      chk("t1_addr", imem_addr, i + 1);
      chk("t1_pc1", if_pc_plus1, i + 1);
      chk("t1_valid", {31'b0, if_valid}, 1);
      chk("t1_instr", if_instr, ADD);
      tick();
    end
    set_in(0, 0, 0);
    chk("t1_cnt", fetch_count, 4);
    tick();

    // 2: redirect, and redirect beating stall
    set_in(0, 1, 8);
    chk("t2_pc", if_pc, 5);
    chk("t2_kill", {31'b0, if_valid}, 0);
    tick();
    set_in(0, 0, 0);
    chk("t2_tgt", if_pc, 8);
    chk("t2_instr", if_instr, 32'h1000_0008);
    chk("t2_valid", {31'b0, if_valid}, 1);
    tick();
    set_in(1, 1, 8);
    chk("t2_both_addr", imem_addr, 8);
    tick();
    set_in(0, 0, 0);
    chk("t2_both_pc", if_pc, 8);
    tick();

    // 3: three-cycle stall at pc 2
    go(0, 1, 2);
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0);
      chk("t3_addr", imem_addr, 2);
      chk("t3_pc", if_pc, 2);
      chk("t3_instr", if_instr, ADD);
      chk("t3_cnt", fetch_count, 7);
      tick();
    end
    set_in(0, 0, 0);
    chk("t3_rel", if_pc, 2);
    tick();
    set_in(0, 0, 0);
    chk("t3_next", if_pc, 3);
    chk("t3_cnt2", fetch_count, 8);
    tick();

    // 4: HLT at 6, stalled for two cycles first
    go(0, 1, 6);
    for (int k = 0; k < 2; k++) begin
      set_in(1, 0, 0);
      chk("t4_stall_halt", {31'b0, halted}, 0);
      chk("t4_stall_valid", {31'b0, if_valid}, 1);
      tick();
    end
    set_in(0, 0, 0);
    chk("t4_hlt_pc", if_pc, 6);
    chk("t4_hlt_valid", {31'b0, if_valid}, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 1023));
      chk("t4_halted", {31'b0, halted}, 1);
      chk("t4_valid", {31'b0, if_valid}, 0);
      chk("t4_addr", imem_addr, 6);
      tick();
    end

    // 5: wrap from 1023 to 0
    set_in(0, 0, 0);
    do_reset();
    go(0, 0, 0);
    go(0, 1, 1023);
    set_in(0, 0, 0);
    chk("t5_pc", if_pc, 1023);
    chk("t5_pc1", if_pc_plus1, 0);
    chk("t5_addr", imem_addr, 0);
    tick();
    set_in(0, 0, 0);
    chk("t5_wrap", if_pc, 0);
    chk("t5_valid", {31'b0, if_valid}, 1);
    tick();

    // 6: reset during a redirect cycle
    set_in(0, 1, 5);
    do_reset();
    set_in(0, 0, 0);
    chk("t6_boot_addr", imem_addr, 0);
    tick();
    set_in(0, 0, 0);
    chk("t6_pc", if_pc, 0);
    chk("t6_valid", {31'b0, if_valid}, 1);
    tick();

    // random traffic with sparse HLT words
    set_in(0, 0, 0);
    do_reset();
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 63) == 0) ? 32'h0
               : ($urandom | 32'h1);
    for (int n = 0; n < 4000; n++) begin
      set_in(1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 6) == 0),
             $urandom_range(0, 1023));
      if ($urandom_range(0, 249) == 0 ||
          (m_phase == 2 && $urandom_range(0, 19) == 0))
        do_reset();
      else
        tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
